// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data formatting, register-file write
// port, sticky load-misalignment flag and retired-instruction counter.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            in_valid,
  input  logic [4:0]      in_rd,
  input  logic            in_regwrite,
  input  logic            in_memtoreg,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_load_data,
  input  logic [2:0]      in_load_type,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_valid,
  output logic            misalign_err,
  output logic [63:0]     instret
);

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  logic            r_valid;
  logic            r_regwrite;
  logic            r_misalign;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic            r_misalign_err;
  logic [63:0]     r_instret;

  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load_fmt;
  logic            w_misalign;
  logic [XLEN-1:0] w_wdata;
  logic            w_advance;

  assign w_off     = in_alu_result[1:0];
  // The stage moves on (retires its content) unless a stall is holding it.
  assign w_advance = !stall_i || flush_i;

  // Little-endian byte/halfword lane selection, sign/zero extension and misalignment detection.
  always_comb begin
    w_byte     = in_load_data[7:0];
    w_half     = w_off[1] ? in_load_data[31:16] : in_load_data[15:0];
    w_load_fmt = in_load_data;
    w_misalign = 1'b0;
    case (w_off)
      2'd0:    w_byte = in_load_data[7:0];
      2'd1:    w_byte = in_load_data[15:8];
      2'd2:    w_byte = in_load_data[23:16];
      default: w_byte = in_load_data[31:24];
    endcase
    case (in_load_type)
      LT_LB:  w_load_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
      LT_LBU: w_load_fmt = {{(XLEN-8){1'b0}}, w_byte};
      LT_LH: begin
        w_load_fmt = {{(XLEN-16){w_half[15]}}, w_half};
        w_misalign = w_off[0];
      end
      LT_LHU: begin
        w_load_fmt = {{(XLEN-16){1'b0}}, w_half};
        w_misalign = w_off[0];
      end
      default: begin
        w_load_fmt = in_load_data;
        w_misalign = (w_off != 2'd0);
      end
    endcase
    // Load type is meaningless for non-load instructions.
    if (!in_memtoreg) begin
      w_misalign = 1'b0;
    end
    if (!in_memtoreg) begin
      w_wdata = in_alu_result;
    end else if (w_misalign) begin
      w_wdata = '0;
    end else begin
      w_wdata = w_load_fmt;
    end
  end

  // WB register: flush inserts a bubble, stall holds, otherwise capture MEM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_misalign <= 1'b0;
      r_rd       <= '0;
      r_wdata    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (!stall_i) begin
      r_valid    <= in_valid;
      r_regwrite <= in_regwrite;
      r_misalign <= w_misalign;
      r_rd       <= in_rd;
      r_wdata    <= w_wdata;
    end
  end

  // Sticky error: latched when a misaligned load leaves the stage; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else if (r_valid && r_misalign && w_advance) begin
      r_misalign_err <= 1'b1;
    end
  end

  // Retire counter: one count per valid instruction leaving the stage, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if (r_valid && w_advance) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  assign wb_valid     = r_valid;
  assign rf_we        = r_valid && r_regwrite && (r_rd != 5'd0) && !r_misalign;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_wdata;
  assign misalign_err = r_misalign_err;
  assign instret      = r_instret;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed vectors per feature.
module tb_mem_wb_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            stall_i;
  logic            flush_i;
  logic            in_valid;
  logic [4:0]      in_rd;
  logic            in_regwrite;
  logic            in_memtoreg;
  logic [XLEN-1:0] in_alu_result;
  logic [XLEN-1:0] in_load_data;
  logic [2:0]      in_load_type;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            wb_valid;
  logic            misalign_err;
  logic [63:0]     instret;

  int vectors = 0;
  int errors  = 0;

  mem_wb_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_memtoreg(in_memtoreg), .in_alu_result(in_alu_result),
    .in_load_data(in_load_data), .in_load_type(in_load_type),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .misalign_err(misalign_err), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] data, input logic [2:0] lt);
    in_valid      = v;
    in_rd         = rd;
    in_regwrite   = rw;
    in_memtoreg   = m2r;
    in_alu_result = alu;
    in_load_data  = data;
    in_load_type  = lt;
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    bubble();
    #2;
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
    vectors++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got %b want 0", rf_we); end
    vectors++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_rf_waddr got %0d want 0", rf_waddr); end
    vectors++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL rst_rf_wdata got %h want 0", rf_wdata); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", misalign_err); end
    vectors++; if (instret !== 64'h0) begin errors++; $display("FAIL rst_instret got %h want 0", instret); end
    step(); step();
    #2 rst_n = 1'b1;
    step();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL post_rst_bubble got %b want 0", wb_valid); end
    $display("test_reset done");
  endtask

  // instret: 0 -> 4 over this task (four loads retire).
  task automatic test_loads();
    drive(1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_1003, 32'h80FF_1234, 3'b000);
    step();
    vectors++; if (rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", rf_wdata); end
    vectors++; if (rf_we !== 1'b1) begin errors++; $display("FAIL lb_we got %b want 1", rf_we); end
    vectors++; if (rf_waddr !== 5'd3) begin errors++; $display("FAIL lb_waddr got %0d want 3", rf_waddr); end
    vectors++; if (instret !== 64'd0) begin errors++; $display("FAIL lb_instret got %0d want 0", instret); end
    drive(1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_1003, 32'h80FF_1234, 3'b100);
    step();
    vectors++; if (rf_wdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", rf_wdata); end
    vectors++; if (instret !== 64'd1) begin errors++; $display("FAIL lbu_instret got %0d want 1", instret); end
    drive(1'b1, 5'd8, 1'b1, 1'b1, 32'h0000_2002, 32'h8001_7FFF, 3'b001);
    step();
    vectors++; if (rf_wdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", rf_wdata); end
    vectors++; if (rf_we !== 1'b1) begin errors++; $display("FAIL lh_we got %b want 1", rf_we); end
    drive(1'b1, 5'd8, 1'b1, 1'b1, 32'h0000_2001, 32'h8001_7FFF, 3'b001);
    step();
    vectors++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lh_mis_we got %b want 0", rf_we); end
    vectors++; if (rf_wdata !== 32'h0) begin errors++; $display("FAIL lh_mis_data got %h want 0", rf_wdata); end
    vectors++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL lh_mis_early got %b want 0", misalign_err); end
    bubble();
    step();
    vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lh_mis_err got %b want 1", misalign_err); end
    vectors++; if (instret !== 64'd4) begin errors++; $display("FAIL mis_instret got %0d want 4", instret); end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky[%0d] got %b want 1", i, misalign_err); end
    end
    $display("test_loads done");
  endtask

  // instret: 4 -> 5.
  task automatic test_alu();
    drive(1'b1, 5'd0, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 3'b000);
    step();
    vectors++; if (rf_we !== 1'b0) begin errors++; $display("FAIL alu_rd0_we got %b want 0", rf_we); end
    vectors++; if (instret !== 64'd4) begin errors++; $display("FAIL alu_rd0_instret got %0d want 4", instret); end
    drive(1'b1, 5'd5, 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FFFF, 3'b000);
    step();
    vectors++; if (instret !== 64'd5) begin errors++; $display("FAIL alu_retire got %0d want 5", instret); end
    vectors++; if (rf_we !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", rf_we); end
    vectors++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d want 5", rf_waddr); end
    vectors++; if (rf_wdata !== 32'h0000_1234) begin errors++; $display("FAIL alu_data got %h want 00001234", rf_wdata); end
    $display("test_alu done");
  endtask

  // instret: 5 -> 7.
  task automatic test_stall_flush();
    drive(1'b1, 5'd7, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0, 3'b010);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (rf_wdata !== 32'h0000_1234 || rf_waddr !== 5'd5 || rf_we !== 1'b1)
        begin errors++; $display("FAIL stall_hold[%0d] got we=%b a=%0d d=%h want 1/5/00001234", i, rf_we, rf_waddr, rf_wdata); end
      vectors++; if (instret !== 64'd5) begin errors++; $display("FAIL stall_instret[%0d] got %0d want 5", i, instret); end
    end
    stall_i = 1'b0;
    step();
    vectors++; if (instret !== 64'd6) begin errors++; $display("FAIL stall_release got %0d want 6", instret); end
    vectors++; if (rf_wdata !== 32'h0000_ABCD) begin errors++; $display("FAIL stall_next got %h want 0000abcd", rf_wdata); end
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    vectors++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", wb_valid); end
    vectors++; if (rf_we !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", rf_we); end
    vectors++; if (instret !== 64'd7) begin errors++; $display("FAIL flush_instret got %0d want 7", instret); end
    stall_i = 1'b0; flush_i = 1'b0;
    drive(1'b0, 5'd9, 1'b1, 1'b0, 32'h0000_0099, 32'h0, 3'b010);
    step();
    vectors++; if (wb_valid !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL bubble_cap got v=%b we=%b want 0/0", wb_valid, rf_we); end
    step();
    vectors++; if (instret !== 64'd7) begin errors++; $display("FAIL bubble_instret got %0d want 7", instret); end
    $display("test_stall_flush done");
  endtask

  task automatic test_wrap_and_async_reset();
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    drive(1'b1, 5'd2, 1'b1, 1'b0, 32'h0000_0042, 32'h0, 3'b010);
    step();
    vectors++; if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_pre got %h want ffffffffffffffff", instret); end
    step();
    vectors++; if (instret !== 64'h0) begin errors++; $display("FAIL wrap got %h want 0", instret); end
    vectors++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL inflight_valid got %b want 1", wb_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (wb_valid !== 1'b0 || rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || misalign_err !== 1'b0 || instret !== 64'h0)
      begin errors++; $display("FAIL async_rst got v=%b we=%b a=%0d d=%h me=%b n=%0d want all 0", wb_valid, rf_we, rf_waddr, rf_wdata, misalign_err, instret); end
    #1 rst_n = 1'b1;
    drive(1'b1, 5'd4, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 3'b010);
    step();
    vectors++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000_0055) begin errors++; $display("FAIL first_cap got we=%b d=%h want 1/00000055", rf_we, rf_wdata); end
    vectors++; if (instret !== 64'd0) begin errors++; $display("FAIL rst_discard got %0d want 0", instret); end
    $display("test_wrap_and_async_reset done");
  endtask

  task automatic test_word_and_misc();
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 3'b011);
    step();
    vectors++; if (rf_wdata !== 32'hDEAD_BEEF || rf_we !== 1'b1) begin errors++; $display("FAIL reserved_lw got we=%b d=%h want 1/deadbeef", rf_we, rf_wdata); end
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_3002, 32'hDEAD_BEEF, 3'b010);
    step();
    vectors++; if (rf_wdata !== 32'h0 || rf_we !== 1'b0) begin errors++; $display("FAIL lw_mis got we=%b d=%h want 0/0", rf_we, rf_wdata); end
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_3002, 32'h8001_7FFF, 3'b101);
    step();
    vectors++; if (rf_wdata !== 32'h0000_8001 || rf_we !== 1'b1) begin errors++; $display("FAIL lhu got we=%b d=%h want 1/00008001", rf_we, rf_wdata); end
    vectors++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL lw_mis_err got %b want 1", misalign_err); end
    drive(1'b1, 5'd6, 1'b1, 1'b0, 32'h0000_1235, 32'h0, 3'b001);
    step();
    vectors++; if (rf_wdata !== 32'h0000_1235 || rf_we !== 1'b1) begin errors++; $display("FAIL alu_ignore_lt got we=%b d=%h want 1/00001235", rf_we, rf_wdata); end
    drive(1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_3001, 32'h8001_7FFF, 3'b000);
    step();
    vectors++; if (rf_wdata !== 32'h0000_007F || rf_we !== 1'b1) begin errors++; $display("FAIL lb_off1 got we=%b d=%h want 1/0000007f", rf_we, rf_wdata); end
    $display("test_word_and_misc done");
  endtask

  initial begin
    test_reset();
    test_loads();
    test_alu();
    test_stall_flush();
    test_wrap_and_async_reset();
    test_word_and_misc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
